// File: rtl/present_key_sched_ctrl_pkg.sv
// Shared constants, state encoding and the PRESENT S-box for the key schedule sequencer.
package present_pkg;

    localparam int RK_W = 64;
    localparam int N_RK = 32;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        return SBOX[x];
    endfunction

endpackage

// File: rtl/present_key_sched_ctrl_if.sv
// Key-load request and round-key stream between the key schedule and its neighbours.
interface present_key_sched_ctrl_if #(parameter int KEY_W = 80);
    logic             i_start;
    logic [KEY_W-1:0] i_keyIn;
    logic             i_rkReady;
    logic             o_busy;
    logic             o_rkValid;
    logic [63:0]      o_rk;
    logic [4:0]       o_rkIdx;
    logic             o_done;

    modport master (
        output i_start, i_keyIn, i_rkReady,
        input  o_busy, o_rkValid, o_rk, o_rkIdx, o_done
    );

    modport slave (
        input  i_start, i_keyIn, i_rkReady,
        output o_busy, o_rkValid, o_rk, o_rkIdx, o_done
    );
endinterface

// File: rtl/present_key_sched_ctrl_key_update.sv
// One PRESENT key-register update step: rotate left 61, S-box the top nibble(s), xor the salt.
module present_key_update
    import present_pkg::*;
#(
    parameter int KEY_W = 80
) (
    input  logic [KEY_W-1:0] i_key,
    input  logic [4:0]       i_salt,
    output logic [KEY_W-1:0] o_nkey
);

    logic [KEY_W-1:0] w_rot;

    assign w_rot = {i_key[KEY_W-62:0], i_key[KEY_W-1:KEY_W-61]};

    generate
        if (KEY_W == 80) begin : g_k80
            always_comb begin
                o_nkey         = w_rot;
                o_nkey[79:76]  = sbox4(w_rot[79:76]);
                o_nkey[19:15]  = w_rot[19:15] ^ i_salt;
            end
        end else if (KEY_W == 128) begin : g_k128
            always_comb begin
                o_nkey          = w_rot;
                o_nkey[127:124] = sbox4(w_rot[127:124]);
                o_nkey[123:120] = sbox4(w_rot[123:120]);
                o_nkey[66:62]   = w_rot[66:62] ^ i_salt;
            end
        end else begin : g_badKeyW
            $error("present_key_update: KEY_W must be 80 or 128");
        end
    endgenerate

endmodule

// File: rtl/present_key_sched_ctrl.sv
// Latches a master key and streams round keys K1..K32 over a valid/ready handshake.
module present_key_sched_ctrl
    import present_pkg::*;
#(
    parameter int KEY_W = 80
) (
    input  logic                      clk,
    input  logic                      rst,
    present_key_sched_ctrl_if.slave   bus
);

    state_t           r_state;
    state_t           w_stateNext;
    logic [KEY_W-1:0] r_keyReg;
    logic [KEY_W-1:0] w_keyNext;
    logic [KEY_W-1:0] w_updKey;
    logic [4:0]       r_rkIdx;
    logic [4:0]       w_idxNext;
    logic [4:0]       w_salt;
    logic             r_done;
    logic             w_doneNext;

    // The salt is the index of the key being produced, so it runs 1..31 and is never 0.
    assign w_salt = r_rkIdx + 5'd1;

    present_key_update #(.KEY_W(KEY_W)) u_keyUpdate (
        .i_key  (r_keyReg),
        .i_salt (w_salt),
        .o_nkey (w_updKey)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_keyReg <= '0;
            r_rkIdx  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_keyReg <= w_keyNext;
            r_rkIdx  <= w_idxNext;
            r_done   <= w_doneNext;
        end
    end

    // Accepting K32 ends the schedule without stepping the key register.
    always_comb begin
        w_stateNext = r_state;
        w_keyNext   = r_keyReg;
        w_idxNext   = r_rkIdx;
        w_doneNext  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.i_start) begin
                    w_keyNext   = bus.i_keyIn;
                    w_idxNext   = '0;
                    w_stateNext = RUN;
                end
            end
            RUN: begin
                if (bus.i_rkReady) begin
                    if (r_rkIdx == 5'(N_RK - 1)) begin
                        w_stateNext = IDLE;
                        w_doneNext  = 1'b1;
                    end else begin
                        w_keyNext = w_updKey;
                        w_idxNext = r_rkIdx + 5'd1;
                    end
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    assign bus.o_busy    = (r_state == RUN);
    assign bus.o_rkValid = (r_state == RUN);
    assign bus.o_rk      = r_keyReg[KEY_W-1 -: RK_W];
    assign bus.o_rkIdx   = r_rkIdx;
    assign bus.o_done    = r_done;

endmodule
